ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver for the CPU's I/O bus; the next generation of our keyboard input block.
- Filters and synchronises ps2_clk and ps2_data, deframes 11-bit frames and checks start, parity and stop bits.
- Optionally folds E0/F0 prefix bytes into a 10-bit key event.
- Buffers results in a full-capacity FIFO that the CPU drains with an active-low read strobe.
- Adds what the previous block lacked: glitch filter, frame timeout/resync, error reporting, fill-level output and prefix decode.

Parameters:
AW, 3, log2 of FIFO depth; depth = 2^AW entries, all usable.
FILTER_LEN, 4, consecutive equal clk samples needed before a filtered line changes (range 1..15).
TIMEOUT, 50000, idle clk cycles after which a partial frame is aborted (1 ms at 50 MHz).
DECODE, 0, 0 = raw bytes; 1 = E0/F0 prefix folding.

Ports:
clk  in  1  system clock, 50 MHz
clr  in  1  reset; asynchronous, active-high
ps2_clk  in  1  PS/2 clock, asynchronous
ps2_data  in  1  PS/2 data, asynchronous
rdn  in  1  read strobe, active low
data  out  10  FIFO head: {brk, ext, code[7:0]}; brk/ext are 0 when DECODE=0
ready  out  1  FIFO not empty
level  out  AW+1  number of entries held, 0..2^AW
overflow  out  1  sticky: a byte was dropped because the FIFO was full
frame_err  out  1  one-cycle pulse on a bad frame or a timeout

Behaviour:
- Reset (clr=1, asynchronous): all of the following are cleared and held while clr=1.
  - Synchroniser and filter state = 1 (idle bus high).
  - Bit counter, pointers, level, overflow, frame_err, brk/ext flags = 0.
  - data = 0, ready = 0.
  - A frame in progress is discarded.
- Input conditioning:
  - Each line passes through a 2-FF synchroniser, then a saturating filter.
  - The filtered value flips only after FILTER_LEN consecutive clk samples disagree with it.
  - A sample is taken on the cycle after the filtered ps2_clk goes 1->0; filtered ps2_data is used.
  - Latency from a pin edge to the sample is 2+FILTER_LEN+1 cycles.
- Deframing (bit counter 0..10):
  - Bit 0 must be 0. If it is 1: no frame_err, counter stays 0 (resynchronises on a glitch).
  - Bits 1..8 are data, LSB first.
  - Bit 9 is parity; the count of ones over data+parity must be odd.
  - Bit 10 is stop and must be 1.
  - At bit 10 the counter always returns to 0.
  - On a parity or stop failure the byte is discarded and frame_err pulses on that cycle.
- Timeout:
  - A separate counter runs while the bit counter is non-zero and is cleared on every sample.
  - When it reaches TIMEOUT: bit counter resets to 0 and frame_err pulses.
- Decode, DECODE=1:
  - A valid byte E0 sets ext; F0 sets brk. Neither is pushed.
  - Any other byte is pushed as {brk, ext, byte}, then both flags clear.
  - Flags also clear on frame_err.
  - Repeated prefixes keep their flags set.
  - E1 and all other bytes are pushed as ordinary codes.
- Decode, DECODE=0: every valid byte is pushed as {2'b00, byte}.
- FIFO:
  - Read and write pointers are AW+1 bits wide. Full = (level == 2^AW); empty = (level == 0).
  - data = mem[r_ptr] when ready, else 0 (combinational).
  - Pop: on every clk edge where rdn=0 and ready=1. Holding rdn low pops once per cycle until empty.
  - Push when not full: writes at w_ptr; w_ptr and level update on the next edge.
  - Push when full with no pop: byte dropped, overflow <= 1.
  - Push and pop on the same edge: both happen and level is unchanged. This holds when full (the push is accepted) and when empty (no pop happens, since ready=0).
  - Pointer wrap-around is natural modulo 2^(AW+1).
  - overflow clears on any pop. If a set and a clear occur on the same edge, set wins.
- ready and level reflect state after the clock edge; a pushed byte is visible the cycle after the push.

Test Plan:
1. Reset, then send frame 0x1C (parity 0, stop 1) -> data=0x01C, ready=1, level=1. Pulse rdn low for one cycle -> ready=0, level=0, data=0.
2. DECODE=1; send E0, F0, 0x75 (parities 0, 1, 0) -> exactly one entry, data=0x375. Then send 0x1C -> data=0x01C, flags cleared.
3. AW=3; send 9 valid bytes 0x01..0x09 with no reads -> level=8, overflow=1 after the 9th. Reads return 0x01..0x08 in order; overflow=0 after the first read.
4. Send 0x1C with the parity bit flipped to 1 -> frame_err pulses exactly one cycle, level stays 0. A following good 0x1C is accepted.
5. Send start bit plus 4 data bits, then hold ps2_clk high for TIMEOUT+10 cycles -> one frame_err pulse and level=0. A following full 0x1C frame is received correctly.
6. Inject 2-cycle low glitches on ps2_clk (FILTER_LEN=4) while idle -> no bit captured, no frame_err. Then FIFO full while rdn=0 during a push -> push accepted, level stays 8, overflow=0.

Source files
------------

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: PS/2 pins, CPU read strobe and FIFO status for ps2_rx_fifo
interface ps2_rx_fifo_if #(parameter int AW = 3);
    logic ps2_clk, ps2_data, rdn;
    logic [9:0] data;
    logic ready, overflow, frame_err;
    logic [AW:0] level;
    modport master (output ps2_clk, ps2_data, rdn, input data, ready, level, overflow, frame_err);
    modport slave (input ps2_clk, ps2_data, rdn, output data, ready, level, overflow, frame_err);
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: filtered PS/2 receiver with optional E0/F0 folding into a CPU-read FIFO
module ps2_rx_fifo #(
    parameter int AW = 3,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT = 50000,
    parameter int DECODE = 0
) (
    input logic clk,
    input logic clr,
    ps2_rx_fifo_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DEPTH = 1 << AW;
    localparam bit DEC = (DECODE != 0);
    logic [1:0] s1, s2, f;
    logic [1:0][3:0] fc;
    logic f_clk_q;
    logic [3:0] bit_cnt;
    logic [8:0] sr;
    logic [TW-1:0] tcnt;
    logic brk, ext;
    logic [AW:0] w_ptr, r_ptr, level;
    logic [9:0] mem [DEPTH];
    logic sample, tmo, stop, good, bad, prefix, push, pop, full, wr;
    assign sample = f_clk_q & ~f[0];
    assign tmo = bit_cnt != 4'd0 && tcnt == TW'(TIMEOUT);
    assign stop = sample && !tmo && bit_cnt == 4'd10;
    assign good = stop && f[1] && ^sr;
    assign bad = stop && !good;
    assign prefix = DEC && (sr[7:0] == 8'hE0 || sr[7:0] == 8'hF0);
    assign push = good && !prefix;
    assign pop = !bus.rdn && bus.ready;
    assign full = level == (AW+1)'(DEPTH);
    assign wr = push && (!full || pop);
    assign bus.ready = level != '0;
    assign bus.level = level;
    assign bus.data = bus.ready ? mem[r_ptr[AW-1:0]] : '0;
    // bit 0 of each vector is ps2_clk, bit 1 is ps2_data
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1 <= '1;
            s2 <= '1;
            f <= '1;
            fc <= '0;
            f_clk_q <= 1'b1;
        end else begin
            s1 <= {bus.ps2_data, bus.ps2_clk};
            s2 <= s1;
            f_clk_q <= f[0];
            for (int i = 0; i < 2; i++)
                if (s2[i] == f[i]) fc[i] <= '0;
                else if (fc[i] == 4'(FILTER_LEN - 1)) begin
                    f[i] <= s2[i];
                    fc[i] <= '0;
                end else fc[i] <= fc[i] + 4'd1;
        end
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bit_cnt <= '0;
            sr <= '0;
            tcnt <= '0;
            brk <= 1'b0;
            ext <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.frame_err <= bad || tmo;
            tcnt <= (sample || tmo || bit_cnt == 4'd0) ? '0 : tcnt + 1'b1;
            if (tmo) bit_cnt <= '0;
            else if (sample) begin
                if (bit_cnt == 4'd0) bit_cnt <= {3'd0, ~f[1]};
                else if (bit_cnt == 4'd10) bit_cnt <= '0;
                else begin
                    sr <= {f[1], sr[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
            if (bad || tmo) {brk, ext} <= 2'b00;
            else if (good && DEC) begin
                if (sr[7:0] == 8'hE0) ext <= 1'b1;
                else if (sr[7:0] == 8'hF0) brk <= 1'b1;
                else {brk, ext} <= 2'b00;
            end
        end
    end
    always_ff @(posedge clk) if (wr) mem[w_ptr[AW-1:0]] <= {brk, ext, sr[7:0]};
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            w_ptr <= '0;
            r_ptr <= '0;
            level <= '0;
            bus.overflow <= 1'b0;
        end else begin
            if (wr) w_ptr <= w_ptr + 1'b1;
            if (pop) r_ptr <= r_ptr + 1'b1;
            level <= level + (AW+1)'(wr) - (AW+1)'(pop);
            if (push && !wr) bus.overflow <= 1'b1;
            else if (pop) bus.overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: raw and prefix-decoding receivers fed the same PS/2 frames, checked against queue models
module tb_ps2_rx_fifo;
    localparam int AW = 3, FL = 4, TO = 2000, HP = 20;
    logic clk = 0, clr = 0, pc = 1, pd = 1, rdn = 1;
    int n_cmp = 0, n_bad = 0, fe0 = 0, fe1 = 0, fs0, fs1;
    logic [9:0] q0[$], q1[$];
    logic ov0 = 0, ov1 = 0, brk = 0, ext = 0;
    always #5 clk = ~clk;
    ps2_rx_fifo_if #(.AW(AW)) b0 ();
    ps2_rx_fifo_if #(.AW(AW)) b1 ();
    assign b0.ps2_clk = pc;
    assign b0.ps2_data = pd;
    assign b0.rdn = rdn;
    assign b1.ps2_clk = pc;
    assign b1.ps2_data = pd;
    assign b1.rdn = rdn;
    ps2_rx_fifo #(.AW(AW), .FILTER_LEN(FL), .TIMEOUT(TO), .DECODE(0)) u0 (.clk(clk), .clr(clr), .bus(b0));
    ps2_rx_fifo #(.AW(AW), .FILTER_LEN(FL), .TIMEOUT(TO), .DECODE(1)) u1 (.clk(clk), .clr(clr), .bus(b1));
    always @(negedge clk) begin
        if (b0.frame_err) fe0++;
        if (b1.frame_err) fe1++;
    end
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic chk_state(string tag);
        @(negedge clk);
        chk({tag, "_lvl0"}, b0.level, q0.size());
        chk({tag, "_rdy0"}, b0.ready, q0.size() != 0);
        chk({tag, "_dat0"}, b0.data, q0.size() != 0 ? q0[0] : 10'h0);
        chk({tag, "_ov0"}, b0.overflow, ov0);
        chk({tag, "_lvl1"}, b1.level, q1.size());
        chk({tag, "_rdy1"}, b1.ready, q1.size() != 0);
        chk({tag, "_dat1"}, b1.data, q1.size() != 0 ? q1[0] : 10'h0);
        chk({tag, "_ov1"}, b1.overflow, ov1);
    endtask
    task automatic model_byte(logic [7:0] b);
        if (q0.size() < 8) q0.push_back({2'b00, b}); else ov0 = 1;
        if (b == 8'hE0) ext = 1;
        else if (b == 8'hF0) brk = 1;
        else begin
            if (q1.size() < 8) q1.push_back({brk, ext, b}); else ov1 = 1;
            brk = 0;
            ext = 0;
        end
    endtask
    task automatic model_pop();
        if (q0.size() != 0) begin void'(q0.pop_front()); ov0 = 0; end
        if (q1.size() != 0) begin void'(q1.pop_front()); ov1 = 0; end
    endtask
    // pop_at_stop pulses rdn on the exact edge the stop bit is sampled (2+FL+1 after the fall)
    task automatic send_raw(logic [10:0] f, int n, bit pop_at_stop);
        for (int i = 0; i < n; i++) begin
            #1 pd = f[i];
            repeat (HP/2) @(posedge clk);
            #1 pc = 0;
            if (pop_at_stop && i == 10) begin
                repeat (2 + FL) @(posedge clk);
                #1 rdn = 0;
                @(posedge clk);
                #1 rdn = 1;
                repeat (HP - 8) @(posedge clk);
            end else repeat (HP) @(posedge clk);
            #1 pc = 1;
            repeat (HP/2) @(posedge clk);
        end
    endtask
    task automatic send(logic [7:0] b, bit bad_par = 0, bit pop_at_stop = 0);
        send_raw({1'b1, ~^b ^ bad_par, b, 1'b0}, 11, pop_at_stop);
        if (bad_par) begin
            brk = 0;
            ext = 0;
        end else begin
            if (pop_at_stop) model_pop();
            model_byte(b);
        end
    endtask
    task automatic rd(string tag);
        chk_state({tag, "_pre"});
        rdn = 0;
        @(negedge clk);
        rdn = 1;
        model_pop();
        chk_state({tag, "_post"});
    endtask
    initial begin
        #1 clr = 1;
        repeat (3) @(posedge clk);
        chk_state("reset");
        chk("reset_fe0", b0.frame_err, 0);
        chk("reset_fe1", b1.frame_err, 0);
        #1 clr = 0;
        repeat (5) @(posedge clk);
        send(8'h1C);
        chk_state("t1");
        rd("t1_rd");
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk_state("t2_prefix");
        send(8'h1C);
        chk_state("t2_plain");
        repeat (4) rd("t2_rd");
        for (int i = 1; i <= 9; i++) begin
            send(8'(i));
            if (i >= 8) chk_state("t3_fill");
        end
        repeat (8) rd("t3_rd");
        send(8'hF0);
        fs0 = fe0;
        fs1 = fe1;
        send(8'h1C, 1);
        chk("t4_fe0", fe0 - fs0, 1);
        chk("t4_fe1", fe1 - fs1, 1);
        chk_state("t4_bad");
        send(8'h1C);
        chk_state("t4_good");
        repeat (2) rd("t4_rd");
        fs0 = fe0;
        fs1 = fe1;
        send_raw({2'b10, 8'h1C, 1'b0}, 5, 0);
        repeat (TO + 10) @(posedge clk);
        chk("t5_fe0", fe0 - fs0, 1);
        chk("t5_fe1", fe1 - fs1, 1);
        chk_state("t5_tmo");
        send(8'h1C);
        chk_state("t5_good");
        rd("t5_rd");
        fs0 = fe0;
        fs1 = fe1;
        #1 pd = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 pc = 0;
            repeat (2) @(posedge clk);
            #1 pc = 1;
            repeat (8) @(posedge clk);
        end
        #1 pd = 1;
        repeat (20) @(posedge clk);
        chk("t6_fe0", fe0 - fs0, 0);
        chk("t6_fe1", fe1 - fs1, 0);
        chk_state("t6_glitch");
        send(8'h1C);
        chk_state("t6_good");
        rd("t6_rd");
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
        chk_state("t6_full");
        send(8'h18, 0, 1);
        chk_state("t6_pushpop");
        repeat (8) rd("t6_rd");
        chk("total_fe0", fe0, 2);
        chk("total_fe1", fe1, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
